// File: rtl/qk_seq_ctrl.sv
// Q/K tile sequencer: loads K rows into the array, waits a fixed gap, streams Q rows
// through execute, then drains the output FIFO before signalling done.
module qk_seq_ctrl #(
    parameter int col        = 8,
    parameter int addr_bw    = 4,
    parameter int gap_cycles = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [addr_bw:0]   num_q,
    input  logic [addr_bw:0]   num_k,
    input  logic               ofifo_valid,
    input  logic               out_ready,
    output logic [addr_bw-1:0] qkmem_add,
    output logic               kmem_rd,
    output logic               qmem_rd,
    output logic               load,
    output logic               execute,
    output logic               ofifo_rd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CW = addr_bw + 1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] Q_MAX = CW'(1 << addr_bw);
    localparam logic [CW-1:0] K_MAX = CW'(col);
    localparam logic [7:0] GAP_LAST = (gap_cycles > 0) ? 8'(gap_cycles - 1) : 8'd0;

    typedef enum logic [3:0] {
        IDLE,
        LD_PRE,
        LD,
        LD_TAIL,
        GAP,
        EX,
        EX_TAIL,
        DRAIN,
        FIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] pop_cnt, pop_cnt_nxt;
    logic [CW-1:0] nq, nq_nxt;
    logic [CW-1:0] nk, nk_nxt;
    logic [7:0]    gap_cnt, gap_cnt_nxt;
    logic          err_q, err_nxt;
    logic          req_legal;
    logic          pop_fire;

    assign req_legal = (num_q != '0) && (num_q <= Q_MAX) &&
                       (num_k != '0) && (num_k <= K_MAX);

    // The only output allowed to follow inputs combinationally: a pop needs both sides ready.
    assign pop_fire = (state == DRAIN) && ofifo_valid && out_ready;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pop_cnt_nxt = pop_cnt;
        nq_nxt      = nq;
        nk_nxt      = nk;
        gap_cnt_nxt = gap_cnt;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_legal) begin
                        state_nxt   = LD_PRE;
                        nq_nxt      = num_q;
                        nk_nxt      = num_k;
                        cnt_nxt     = '0;
                        pop_cnt_nxt = '0;
                        gap_cnt_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LD_PRE: begin
                state_nxt = LD;
                cnt_nxt   = '0;
            end
            LD: begin
                if (cnt == nk - ONE) begin
                    state_nxt = LD_TAIL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            LD_TAIL: begin
                cnt_nxt     = '0;
                gap_cnt_nxt = '0;
                if (gap_cycles == 0) begin
                    state_nxt = EX;
                end else begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = EX;
                    cnt_nxt   = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                end
            end
            EX: begin
                if (cnt == nq - ONE) begin
                    state_nxt = EX_TAIL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            EX_TAIL: begin
                state_nxt   = DRAIN;
                pop_cnt_nxt = '0;
            end
            DRAIN: begin
                if (pop_fire) begin
                    pop_cnt_nxt = pop_cnt + ONE;
                    if (pop_cnt + ONE == nq) begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Abort wins over every other transition; the counters are reloaded on the next start.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pop_cnt <= '0;
            nq      <= '0;
            nk      <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pop_cnt <= pop_cnt_nxt;
            nq      <= nq_nxt;
            nk      <= nk_nxt;
            gap_cnt <= gap_cnt_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        qkmem_add = '0;
        kmem_rd   = 1'b0;
        qmem_rd   = 1'b0;
        load      = 1'b0;
        execute   = 1'b0;
        case (state)
            LD_PRE: begin
                load = 1'b1;
            end
            LD: begin
                load      = 1'b1;
                kmem_rd   = 1'b1;
                qkmem_add = cnt[addr_bw-1:0];
            end
            LD_TAIL: begin
                load = 1'b1;
            end
            EX: begin
                execute   = 1'b1;
                qmem_rd   = 1'b1;
                qkmem_add = cnt[addr_bw-1:0];
            end
            default: begin
            end
        endcase
    end

    assign ofifo_rd = pop_fire;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign err      = err_q;

endmodule

// File: tb/tb_qk_seq_ctrl.sv
// Directed bench for qk_seq_ctrl: one instance with the default gap and one with gap_cycles=0,
// a small output-FIFO model, and per-scenario tasks that compare observations to hand values.
module tb_qk_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start_g0;
    logic       abort;
    logic [4:0] num_q;
    logic [4:0] num_k;
    logic       ofifo_valid;
    logic       out_ready;

    logic [3:0] m_add, z_add, s_add;
    logic m_krd, m_qrd, m_load, m_exe, m_ord, m_busy, m_done, m_err;
    logic z_krd, z_qrd, z_load, z_exe, z_ord, z_busy, z_done, z_err;
    logic s_krd, s_qrd, s_load, s_exe, s_ord, s_busy, s_done, s_err;
    bit   sel;

    int ncheck;
    int nfail;

    int obs_load, obs_pops, obs_done, obs_err, obs_bad_rd, obs_busy_before;
    int obs_last_load, obs_first_ex, obs_done_idx, obs_last_pop, obs_abort_addr;
    bit obs_busy_after, obs_timeout, obs_post_zero;
    logic [3:0] obs_kaddr[$];
    logic [3:0] obs_qaddr[$];

    qk_seq_ctrl #(.col(8), .addr_bw(4), .gap_cycles(10)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_q(num_q), .num_k(num_k), .ofifo_valid(ofifo_valid), .out_ready(out_ready),
        .qkmem_add(m_add), .kmem_rd(m_krd), .qmem_rd(m_qrd), .load(m_load),
        .execute(m_exe), .ofifo_rd(m_ord), .busy(m_busy), .done(m_done), .err(m_err)
    );

    qk_seq_ctrl #(.col(8), .addr_bw(4), .gap_cycles(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start_g0), .abort(abort),
        .num_q(num_q), .num_k(num_k), .ofifo_valid(ofifo_valid), .out_ready(out_ready),
        .qkmem_add(z_add), .kmem_rd(z_krd), .qmem_rd(z_qrd), .load(z_load),
        .execute(z_exe), .ofifo_rd(z_ord), .busy(z_busy), .done(z_done), .err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        s_add  = sel ? z_add  : m_add;
        s_krd  = sel ? z_krd  : m_krd;
        s_qrd  = sel ? z_qrd  : m_qrd;
        s_load = sel ? z_load : m_load;
        s_exe  = sel ? z_exe  : m_exe;
        s_ord  = sel ? z_ord  : m_ord;
        s_busy = sel ? z_busy : m_busy;
        s_done = sel ? z_done : m_done;
        s_err  = sel ? z_err  : m_err;
    end

    function automatic bit all_zero();
        return !(s_krd | s_qrd | s_load | s_exe | s_ord | s_busy | s_done | s_err) && (s_add == 4'd0);
    endfunction

    // Drives one tile and records what the selected instance does; the test tasks judge the record.
    task automatic run_tile(input bit use_g0, input logic [4:0] nq, input logic [4:0] nk,
                            input bit bp, input int abort_addr, input int reset_pops,
                            input bit gap_start, input bit fin_start);
        int rows = 0;
        int gap_idx = 0;
        bit done_seen = 0, load_seen = 0, ex_seen = 0;
        bit abort_armed = 0, abort_fired = 0, reset_fired = 0, post_pending = 0, finished = 0;
        bit reset_now, issue;
        sel = use_g0;
        obs_load = 0; obs_pops = 0; obs_done = 0; obs_err = 0; obs_bad_rd = 0;
        obs_busy_before = 0; obs_last_load = -1; obs_first_ex = -1; obs_done_idx = -1;
        obs_last_pop = -1; obs_abort_addr = -1; obs_busy_after = 1'b1; obs_timeout = 1'b0;
        obs_post_zero = 1'b0;
        obs_kaddr.delete();
        obs_qaddr.delete();
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0; start_g0 = 1'b0; abort = 1'b0; reset = 1'b0;
            num_q = nq; num_k = nk;
            issue = (cyc == 0) && !post_pending;
            if (gap_start && gap_idx == 3 && !post_pending) begin
                issue = 1'b1; num_q = 5'd3; num_k = 5'd3;
            end
            if (fin_start && obs_pops == int'(nq) && !done_seen && !post_pending) issue = 1'b1;
            if (issue) begin
                if (use_g0) start_g0 = 1'b1; else start = 1'b1;
            end
            if (abort_armed && !abort_fired) begin
                abort = 1'b1; abort_fired = 1'b1;
            end
            reset_now = (reset_pops > 0) && (obs_pops == reset_pops) && !reset_fired;
            if (reset_now) begin
                reset = 1'b1; reset_fired = 1'b1;
            end
            out_ready   = reset_now ? 1'b0 : (bp ? (cyc % 3 == 0) : 1'b1);
            ofifo_valid = bp ? 1'b1 : (rows > 0);
            #1;
            if (post_pending) begin
                obs_post_zero = all_zero();
                if (s_done) obs_done++;
                finished = 1'b1;
            end else begin
                if (s_load) begin obs_load++; obs_last_load = cyc; load_seen = 1'b1; end
                if (s_krd) obs_kaddr.push_back(s_add);
                if (s_qrd) obs_qaddr.push_back(s_add);
                if (s_exe && !ex_seen) begin ex_seen = 1'b1; obs_first_ex = cyc; end
                if (s_ord) begin
                    obs_pops++; obs_last_pop = cyc;
                    if (!out_ready || !ofifo_valid) obs_bad_rd++;
                end
                if (s_err) obs_err++;
                if (!done_seen && !s_done && s_busy) obs_busy_before++;
                if (s_done) obs_done++;
                if (done_seen) begin
                    obs_busy_after = s_busy; finished = 1'b1;
                end else if (s_done) begin
                    done_seen = 1'b1; obs_done_idx = cyc;
                end
                if (s_busy && !s_load && !s_exe && load_seen && !ex_seen) gap_idx++;
                if (abort_addr >= 0 && s_exe && int'(s_add) == abort_addr - 1) abort_armed = 1'b1;
                if (abort) obs_abort_addr = int'(s_add);
                rows = rows + (s_exe ? 1 : 0) - (s_ord ? 1 : 0);
                post_pending = abort || reset;
            end
        end
        if (!finished) obs_timeout = 1'b1;
        @(negedge clk);
        start = 1'b0; start_g0 = 1'b0; abort = 1'b0; reset = 1'b0;
        out_ready = 1'b0; ofifo_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; start_g0 = 1'b1; abort = 1'b1;
        num_q = 5'd4; num_k = 5'd4; out_ready = 1'b1; ofifo_valid = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0; #1;
        ncheck++; if (!all_zero()) begin nfail++; $display("[TB] FAIL reset_outputs_main: got nonzero, expected all zero"); end
        sel = 1'b1; #1;
        ncheck++; if (!all_zero()) begin nfail++; $display("[TB] FAIL reset_outputs_g0: got nonzero, expected all zero"); end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; start_g0 = 1'b0; abort = 1'b0;
        out_ready = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk); #1;
        sel = 1'b0; #1;
        ncheck++; if (s_busy !== 1'b0) begin nfail++; $display("[TB] FAIL reset_beats_start_main: busy got %b, expected 0", s_busy); end
        sel = 1'b1; #1;
        ncheck++; if (s_busy !== 1'b0) begin nfail++; $display("[TB] FAIL reset_beats_start_g0: busy got %b, expected 0", s_busy); end
    endtask

    task automatic test_nominal(input string tag);
        run_tile(1'b0, 5'd8, 5'd8, 1'b0, -1, -1, 1'b0, 1'b1);
        ncheck++; if (obs_timeout) begin nfail++; $display("[TB] FAIL %s_timeout: got timeout, expected done", tag); end
        ncheck++; if (obs_load != 10) begin nfail++; $display("[TB] FAIL %s_load_cycles: got %0d, expected 10", tag, obs_load); end
        ncheck++; if (obs_kaddr.size() != 8) begin nfail++; $display("[TB] FAIL %s_kmem_reads: got %0d, expected 8", tag, obs_kaddr.size()); end
        for (int i = 0; i < obs_kaddr.size(); i++) begin
            ncheck++; if (obs_kaddr[i] !== 4'(i)) begin nfail++; $display("[TB] FAIL %s_kaddr[%0d]: got %0d, expected %0d", tag, i, obs_kaddr[i], i); end
        end
        ncheck++; if (obs_qaddr.size() != 8) begin nfail++; $display("[TB] FAIL %s_qmem_reads: got %0d, expected 8", tag, obs_qaddr.size()); end
        for (int i = 0; i < obs_qaddr.size(); i++) begin
            ncheck++; if (obs_qaddr[i] !== 4'(i)) begin nfail++; $display("[TB] FAIL %s_qaddr[%0d]: got %0d, expected %0d", tag, i, obs_qaddr[i], i); end
        end
        ncheck++; if (obs_first_ex - obs_last_load - 1 != 10) begin nfail++; $display("[TB] FAIL %s_gap: got %0d, expected 10", tag, obs_first_ex - obs_last_load - 1); end
        ncheck++; if (obs_pops != 8) begin nfail++; $display("[TB] FAIL %s_pops: got %0d, expected 8", tag, obs_pops); end
        ncheck++; if (obs_done != 1) begin nfail++; $display("[TB] FAIL %s_done_cycles: got %0d, expected 1", tag, obs_done); end
        ncheck++; if (obs_busy_before != 37) begin nfail++; $display("[TB] FAIL %s_latency: got %0d, expected 37", tag, obs_busy_before); end
        ncheck++; if (obs_busy_after !== 1'b0) begin nfail++; $display("[TB] FAIL %s_busy_after_done: got %b, expected 0", tag, obs_busy_after); end
        ncheck++; if (obs_err != 0) begin nfail++; $display("[TB] FAIL %s_err_on_fin_start: got %0d, expected 0", tag, obs_err); end
        ncheck++; if (obs_bad_rd != 0) begin nfail++; $display("[TB] FAIL %s_bad_pop: got %0d, expected 0", tag, obs_bad_rd); end
    endtask

    task automatic test_backpressure;
        run_tile(1'b0, 5'd5, 5'd3, 1'b1, -1, -1, 1'b0, 1'b0);
        ncheck++; if (obs_timeout) begin nfail++; $display("[TB] FAIL bp_timeout: got timeout, expected done"); end
        ncheck++; if (obs_pops != 5) begin nfail++; $display("[TB] FAIL bp_pops: got %0d, expected 5", obs_pops); end
        ncheck++; if (obs_bad_rd != 0) begin nfail++; $display("[TB] FAIL bp_pop_without_ready: got %0d, expected 0", obs_bad_rd); end
        ncheck++; if (obs_done != 1) begin nfail++; $display("[TB] FAIL bp_done_cycles: got %0d, expected 1", obs_done); end
        ncheck++; if (obs_done_idx != obs_last_pop + 1) begin nfail++; $display("[TB] FAIL bp_done_after_last_pop: got %0d, expected %0d", obs_done_idx, obs_last_pop + 1); end
        ncheck++; if (obs_load != 5) begin nfail++; $display("[TB] FAIL bp_load_cycles: got %0d, expected 5", obs_load); end
    endtask

    task automatic test_boundary;
        run_tile(1'b1, 5'd16, 5'd1, 1'b0, -1, -1, 1'b0, 1'b0);
        ncheck++; if (obs_timeout) begin nfail++; $display("[TB] FAIL bnd_timeout: got timeout, expected done"); end
        ncheck++; if (obs_kaddr.size() != 1) begin nfail++; $display("[TB] FAIL bnd_ld_cycles: got %0d, expected 1", obs_kaddr.size()); end
        ncheck++; if (obs_load != 3) begin nfail++; $display("[TB] FAIL bnd_load_cycles: got %0d, expected 3", obs_load); end
        ncheck++; if (obs_qaddr.size() != 16) begin nfail++; $display("[TB] FAIL bnd_qmem_reads: got %0d, expected 16", obs_qaddr.size()); end
        for (int i = 0; i < obs_qaddr.size(); i++) begin
            ncheck++; if (obs_qaddr[i] !== 4'(i)) begin nfail++; $display("[TB] FAIL bnd_qaddr[%0d]: got %0d, expected %0d", i, obs_qaddr[i], i); end
        end
        ncheck++; if (obs_first_ex != obs_last_load + 1) begin nfail++; $display("[TB] FAIL bnd_ex_after_tail: got %0d, expected %0d", obs_first_ex, obs_last_load + 1); end
        ncheck++; if (obs_pops != 16) begin nfail++; $display("[TB] FAIL bnd_pops: got %0d, expected 16", obs_pops); end
        ncheck++; if (obs_busy_before != 36) begin nfail++; $display("[TB] FAIL bnd_latency: got %0d, expected 36", obs_busy_before); end
    endtask

    task automatic test_illegal;
        logic [4:0] qv[4];
        logic [4:0] kv[4];
        int errs, busys;
        qv = '{5'd0, 5'd4, 5'd17, 5'd4};
        kv = '{5'd4, 5'd9, 5'd4, 5'd0};
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            errs = 0; busys = 0;
            @(negedge clk);
            start = 1'b1; num_q = qv[i]; num_k = kv[i];
            #1;
            if (s_err) errs++;
            if (s_busy) busys++;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                if (s_err) errs++;
                if (s_busy) busys++;
            end
            ncheck++; if (errs != 1) begin nfail++; $display("[TB] FAIL illegal_err q=%0d k=%0d: got %0d pulses, expected 1", qv[i], kv[i], errs); end
            ncheck++; if (busys != 0) begin nfail++; $display("[TB] FAIL illegal_busy q=%0d k=%0d: got %0d, expected 0", qv[i], kv[i], busys); end
        end
    endtask

    task automatic test_busy_abort;
        run_tile(1'b0, 5'd8, 5'd8, 1'b0, 3, -1, 1'b1, 1'b0);
        ncheck++; if (obs_timeout) begin nfail++; $display("[TB] FAIL abort_timeout: got timeout, expected abort"); end
        ncheck++; if (obs_err != 0) begin nfail++; $display("[TB] FAIL gap_start_err: got %0d, expected 0", obs_err); end
        ncheck++; if (obs_load != 10) begin nfail++; $display("[TB] FAIL gap_start_ignored: load got %0d, expected 10", obs_load); end
        ncheck++; if (obs_first_ex - obs_last_load - 1 != 10) begin nfail++; $display("[TB] FAIL gap_start_gap: got %0d, expected 10", obs_first_ex - obs_last_load - 1); end
        ncheck++; if (obs_abort_addr != 3) begin nfail++; $display("[TB] FAIL abort_addr: got %0d, expected 3", obs_abort_addr); end
        ncheck++; if (obs_qaddr.size() != 4) begin nfail++; $display("[TB] FAIL abort_qmem_reads: got %0d, expected 4", obs_qaddr.size()); end
        ncheck++; if (!obs_post_zero) begin nfail++; $display("[TB] FAIL abort_outputs: got nonzero, expected all zero"); end
        ncheck++; if (obs_done != 0) begin nfail++; $display("[TB] FAIL abort_done: got %0d, expected 0", obs_done); end
        test_nominal("after_abort");
    endtask

    task automatic test_reset_drain;
        run_tile(1'b0, 5'd8, 5'd8, 1'b0, -1, 4, 1'b0, 1'b0);
        ncheck++; if (obs_timeout) begin nfail++; $display("[TB] FAIL rst_drain_timeout: got timeout, expected reset"); end
        ncheck++; if (obs_pops != 4) begin nfail++; $display("[TB] FAIL rst_drain_pops: got %0d, expected 4", obs_pops); end
        ncheck++; if (!obs_post_zero) begin nfail++; $display("[TB] FAIL rst_drain_outputs: got nonzero, expected all zero"); end
        ncheck++; if (obs_done != 0) begin nfail++; $display("[TB] FAIL rst_drain_done: got %0d, expected 0", obs_done); end
        test_nominal("after_reset");
    endtask

    initial begin
        ncheck = 0; nfail = 0; sel = 1'b0;
        reset = 1'b1; start = 1'b0; start_g0 = 1'b0; abort = 1'b0;
        num_q = 5'd0; num_k = 5'd0; ofifo_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_nominal("nominal");
        test_backpressure();
        test_boundary();
        test_illegal();
        test_busy_abort();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
